// File: rtl/lcd_cmd_seq.sv
// LCD command sequencer: walks a command-script ROM, strobes commands to the
// controller and captures 64 write-back bytes with a running checksum.
// Optional build macro LCD_SEQ_TIMEOUT_EN adds an 8-bit stall watchdog.
module lcd_cmd_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        busy,
  input  logic        done_lcd,
  output logic [2:0]  cmd,
  output logic        cmd_valid,
  output logic [4:0]  CROM_A,
  input  logic [2:0]  CROM_Q,
  input  logic        IRB_RW,
  input  logic [5:0]  IRB_A,
  input  logic [7:0]  IRB_D,
  input  logic [5:0]  rd_a,
  output logic [7:0]  rd_q,
  output logic [15:0] checksum,
  output logic        seq_done,
  output logic        err
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WAITB = 3'd1,
    ISSUE = 3'd2,
    GAP   = 3'd3,
    CAPT  = 3'd4,
    FIN   = 3'd5
  } state_t;

  state_t      state_r, state_s;
  logic [2:0]  cmd_r, cmd_s;
  logic        cmd_valid_r, cmd_valid_s;
  logic [4:0]  crom_a_r, crom_a_s;
  logic [15:0] checksum_r, checksum_s;
  logic        seq_done_r, seq_done_s;
  logic        err_r, err_s;
  logic [6:0]  wcnt_r, wcnt_s;
  // Set once entry 31 has been issued non-zero; the next issue is a forced write-back.
  logic        ovf_r, ovf_s;
  logic        wr_en_s;
  logic [7:0]  buf_r [0:63];

`ifdef LCD_SEQ_TIMEOUT_EN
  logic [7:0]  wd_r, wd_s;
  logic        wd_tick_s;

  assign wd_tick_s = ((state_r == WAITB) && busy) || ((state_r == CAPT) && IRB_RW);
`endif

  // Next-state and next-value logic for every registered result.
  always_comb begin
    state_s     = state_r;
    cmd_s       = cmd_r;
    cmd_valid_s = 1'b0;
    crom_a_s    = crom_a_r;
    checksum_s  = checksum_r;
    seq_done_s  = seq_done_r;
    err_s       = err_r;
    wcnt_s      = wcnt_r;
    ovf_s       = ovf_r;
    wr_en_s     = 1'b0;
`ifdef LCD_SEQ_TIMEOUT_EN
    wd_s        = wd_r;
`endif
    case (state_r)
      IDLE, FIN: begin
        if (start) begin
          crom_a_s   = 5'd0;
          checksum_s = 16'd0;
          wcnt_s     = 7'd0;
          err_s      = 1'b0;
          ovf_s      = 1'b0;
          seq_done_s = 1'b0;
          state_s    = WAITB;
        end else begin
          state_s    = state_r;
        end
      end
      WAITB: begin
        if (!busy) begin
          state_s     = ISSUE;
          cmd_valid_s = 1'b1;
          if (ovf_r) begin
            cmd_s = 3'd0;
            err_s = 1'b1;
          end else begin
            cmd_s = CROM_Q;
          end
        end else begin
          state_s = WAITB;
        end
      end
      ISSUE: begin
        if (cmd_r != 3'd0) begin
          state_s = GAP;
          if (crom_a_r == 5'd31) begin
            ovf_s = 1'b1;
          end else begin
            crom_a_s = crom_a_r + 5'd1;
          end
        end else begin
          state_s = CAPT;
        end
      end
      GAP: begin
        state_s = WAITB;
      end
      CAPT: begin
        if (!IRB_RW) begin
          wr_en_s    = 1'b1;
          checksum_s = checksum_r + {8'd0, IRB_D};
          wcnt_s     = wcnt_r + 7'd1;
        end else begin
          wr_en_s    = 1'b0;
        end
        // A write on the same edge as done_lcd is already folded in above.
        if (wcnt_s == 7'd64) begin
          state_s    = FIN;
          seq_done_s = 1'b1;
        end else if (done_lcd) begin
          state_s    = FIN;
          seq_done_s = 1'b1;
          err_s      = 1'b1;
        end else begin
          state_s    = CAPT;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
`ifdef LCD_SEQ_TIMEOUT_EN
    if (state_s != state_r) begin
      wd_s = 8'd0;
    end else if (wd_tick_s) begin
      if (wd_r == 8'd254) begin
        wd_s       = 8'd0;
        err_s      = 1'b1;
        seq_done_s = 1'b1;
        state_s    = FIN;
      end else begin
        wd_s       = wd_r + 8'd1;
      end
    end else begin
      wd_s = 8'd0;
    end
`endif
  end

  // State and result registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      cmd_r       <= 3'd0;
      cmd_valid_r <= 1'b0;
      crom_a_r    <= 5'd0;
      checksum_r  <= 16'd0;
      seq_done_r  <= 1'b0;
      err_r       <= 1'b0;
      wcnt_r      <= 7'd0;
      ovf_r       <= 1'b0;
    end else begin
      state_r     <= state_s;
      cmd_r       <= cmd_s;
      cmd_valid_r <= cmd_valid_s;
      crom_a_r    <= crom_a_s;
      checksum_r  <= checksum_s;
      seq_done_r  <= seq_done_s;
      err_r       <= err_s;
      wcnt_r      <= wcnt_s;
      ovf_r       <= ovf_s;
    end
  end

`ifdef LCD_SEQ_TIMEOUT_EN
  // Watchdog counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd_r <= 8'd0;
    end else begin
      wd_r <= wd_s;
    end
  end
`endif

  // Capture buffer; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      buf_r[IRB_A] <= IRB_D;
    end
  end

  assign rd_q      = buf_r[rd_a];
  assign cmd       = cmd_r;
  assign cmd_valid = cmd_valid_r;
  assign CROM_A    = crom_a_r;
  assign checksum  = checksum_r;
  assign seq_done  = seq_done_r;
  assign err       = err_r;

endmodule

// File: tb/tb_lcd_cmd_seq.sv
// Directed self-checking bench for lcd_cmd_seq (script issue, capture,
// overflow, early done, async reset, busy stall with/without watchdog).
module tb_lcd_cmd_seq;

  logic        clk = 1'b0;
  logic        reset, start, busy, done_lcd;
  logic [2:0]  cmd;
  logic        cmd_valid;
  logic [4:0]  CROM_A;
  logic [2:0]  CROM_Q;
  logic        IRB_RW;
  logic [5:0]  IRB_A;
  logic [7:0]  IRB_D;
  logic [5:0]  rd_a;
  logic [7:0]  rd_q;
  logic [15:0] checksum;
  logic        seq_done, err;

  logic [2:0]  rom [0:31];
  assign CROM_Q = rom[CROM_A];

  always #5 clk = ~clk;

  lcd_cmd_seq dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done_lcd(done_lcd),
    .cmd(cmd), .cmd_valid(cmd_valid), .CROM_A(CROM_A), .CROM_Q(CROM_Q),
    .IRB_RW(IRB_RW), .IRB_A(IRB_A), .IRB_D(IRB_D), .rd_a(rd_a), .rd_q(rd_q),
    .checksum(checksum), .seq_done(seq_done), .err(err)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int npulse, hold_bad, seen;
  logic [2:0] pcmd [0:63];
  int         pcyc [0:63];
  logic       perr [0:63];
  logic [4:0] pa   [0:63];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Record up to n strobes within budget cycles; also watch that cmd holds between them.
  task automatic collect(input int n, input int budget);
    npulse   = 0;
    hold_bad = 0;
    for (int k = 0; k < budget && npulse < n; k++) begin
      tick();
      if (cmd_valid) begin
        pcmd[npulse] = cmd;
        pcyc[npulse] = cyc;
        perr[npulse] = err;
        pa[npulse]   = CROM_A;
        npulse++;
      end else if (npulse > 0 && cmd !== pcmd[npulse-1]) begin
        hold_bad++;
      end
    end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; busy = 1'b1; done_lcd = 1'b0;
    IRB_RW = 1'b1; IRB_A = 6'd0; IRB_D = 8'd0; rd_a = 6'd0;
    for (int i = 0; i < 32; i++) rom[i] = 3'd7;
    rom[0] = 3'd1; rom[1] = 3'd3; rom[2] = 3'd5; rom[3] = 3'd0;

    // Reset values
    repeat (3) tick();
    chk("rst_cmd", cmd, 3'd0);
    chk("rst_valid", cmd_valid, 1'b0);
    chk("rst_crom_a", CROM_A, 5'd0);
    chk("rst_checksum", checksum, 16'd0);
    chk("rst_seq_done", seq_done, 1'b0);
    chk("rst_err", err, 1'b0);
    reset = 1'b1;
    tick();

    // Script {1,3,5,0} behind 70 busy clocks, then 64 writes of i
    do_start();
    seen = 0;
    repeat (70) begin tick(); if (cmd_valid) seen++; end
    chk("busy_block", seen, 0);
    busy = 1'b0;
    collect(4, 40);
    chk("pulse_count", npulse, 4);
    chk("cmd0", pcmd[0], 3'd1);
    chk("cmd1", pcmd[1], 3'd3);
    chk("cmd2", pcmd[2], 3'd5);
    chk("cmd3", pcmd[3], 3'd0);
    for (int k = 1; k < 4; k++) chk("gap_ge3", (pcyc[k] - pcyc[k-1]) >= 3, 1'b1);
    chk("cmd_hold", hold_bad, 0);
    chk("crom_a_at_wb", pa[3], 5'd3);
    IRB_RW = 1'b0; IRB_A = 6'd10; IRB_D = 8'hAA;
    tick();
    for (int i = 0; i < 64; i++) begin
      IRB_RW = 1'b0; IRB_A = 6'(i); IRB_D = 8'(i); start = (i == 5);
      tick();
    end
    IRB_RW = 1'b1; start = 1'b0;
    chk("run_seq_done", seq_done, 1'b1);
    chk("run_err", err, 1'b0);
    chk("run_checksum", checksum, 16'd2016);
    chk("fin_valid", cmd_valid, 1'b0);
    rd_a = 6'd10; #1;
    chk("rd_q_10", rd_q, 8'd10);
    rd_a = 6'd63; #1;
    chk("rd_q_63", rd_q, 8'd63);
    repeat (3) tick();
    chk("fin_hold_done", seq_done, 1'b1);
    chk("fin_hold_sum", checksum, 16'd2016);

    // Script overflow: 32 non-zero entries
    for (int i = 0; i < 32; i++) rom[i] = 3'((i % 7) + 1);
    do_start();
    chk("restart_clr_done", seq_done, 1'b0);
    chk("restart_clr_sum", checksum, 16'd0);
    collect(33, 200);
    chk("ovf_pulses", npulse, 33);
    chk("ovf_cmd31", pcmd[31], rom[31]);
    chk("ovf_err31", perr[31], 1'b0);
    chk("ovf_a31", pa[31], 5'd31);
    chk("ovf_cmd32", pcmd[32], 3'd0);
    chk("ovf_err32", perr[32], 1'b1);
    chk("ovf_a32", pa[32], 5'd31);
    chk("ovf_hold", hold_bad, 0);
    tick();
    done_lcd = 1'b1;
    tick();
    done_lcd = 1'b0;
    chk("ovf_done", seq_done, 1'b1);
    chk("ovf_sum", checksum, 16'd0);
    chk("ovf_a_fin", CROM_A, 5'd31);

    // Early done_lcd on the 40th write of 0xFF
    rom[0] = 3'd0;
    do_start();
    chk("restart_clr_err", err, 1'b0);
    collect(1, 10);
    chk("early_cmd", pcmd[0], 3'd0);
    tick();
    for (int i = 0; i < 40; i++) begin
      IRB_RW = 1'b0; IRB_A = 6'(i); IRB_D = 8'hFF; done_lcd = (i == 39);
      tick();
    end
    IRB_RW = 1'b1; done_lcd = 1'b0;
    chk("early_done", seq_done, 1'b1);
    chk("early_err", err, 1'b1);
    chk("early_sum", checksum, 16'd10200);
    chk("early_a", CROM_A, 5'd0);
    rd_a = 6'd39; #1;
    chk("early_rd", rd_q, 8'hFF);

    // Async reset mid-CAPT, then a full-scale normal run
    rom[0] = 3'd2; rom[1] = 3'd0;
    do_start();
    collect(2, 20);
    tick();
    for (int i = 0; i < 5; i++) begin
      IRB_RW = 1'b0; IRB_A = 6'(i); IRB_D = 8'h11;
      tick();
    end
    IRB_RW = 1'b1;
    #2 reset = 1'b0;
    #1;
    chk("arst_cmd", cmd, 3'd0);
    chk("arst_valid", cmd_valid, 1'b0);
    chk("arst_crom_a", CROM_A, 5'd0);
    chk("arst_sum", checksum, 16'd0);
    chk("arst_done", seq_done, 1'b0);
    chk("arst_err", err, 1'b0);
    tick();
    reset = 1'b1;
    tick();
    do_start();
    collect(2, 20);
    chk("post_cmd0", pcmd[0], 3'd2);
    chk("post_cmd1", pcmd[1], 3'd0);
    tick();
    for (int i = 0; i < 64; i++) begin
      IRB_RW = 1'b0; IRB_A = 6'(i); IRB_D = 8'hFF;
      tick();
    end
    IRB_RW = 1'b1;
    chk("max_sum", checksum, 16'd16320);
    chk("max_done", seq_done, 1'b1);
    chk("max_err", err, 1'b0);
    chk("max_a", CROM_A, 5'd1);

    // busy held high in WAITB
    busy = 1'b1;
    do_start();
`ifdef LCD_SEQ_TIMEOUT_EN
    seen = 0;
    for (int k = 0; k < 300 && !seq_done; k++) begin
      tick();
      seen++;
    end
    chk("wd_cycles", seen, 255);
    chk("wd_err", err, 1'b1);
    chk("wd_done", seq_done, 1'b1);
`else
    seen = 0;
    repeat (1000) begin tick(); if (cmd_valid || seq_done) seen++; end
    chk("stall_quiet", seen, 0);
    chk("stall_err", err, 1'b0);
    busy = 1'b0;
    collect(1, 5);
    chk("stall_resume", npulse, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lcd_cmd_seq.md
LCD_CMD_SEQ -- requirements
Module: lcd_cmd_seq

Interface
REQ-001 SHALL have port clk, input, 1 bit: single rising-edge clock for all state.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-low reset (0 = reset).
REQ-003 SHALL have port start, input, 1 bit: begins a run; sampled only in IDLE or FIN.
REQ-004 SHALL have port busy, input, 1 bit: controller busy flag; commands are issued only when it is low.
REQ-005 SHALL have port done_lcd, input, 1 bit: controller done flag.
REQ-006 SHALL have port cmd, output, 3 bits: command code driven to the controller.
REQ-007 SHALL have port cmd_valid, output, 1 bit: command strobe.
REQ-008 SHALL have port CROM_A, output, 5 bits: command-script ROM address.
REQ-009 SHALL have port CROM_Q, input, 3 bits: script entry at CROM_A, combinational read.
REQ-010 SHALL have port IRB_RW, input, 1 bit: 0 = write cycle from the controller.
REQ-011 SHALL have ports IRB_A (input, 6 bits) and IRB_D (input, 8 bits): write-back address and data.
REQ-012 SHALL have ports rd_a (input, 6 bits) and rd_q (output, 8 bits): combinational readback of the capture buffer.
REQ-013 SHALL have port checksum, output, 16 bits: sum of all captured write-back bytes.
REQ-014 SHALL have ports seq_done (output, 1 bit) and err (output, 1 bit): run-complete flag and error flag.

Function
REQ-015 SHALL implement states IDLE, WAITB, ISSUE, GAP, CAPT, FIN.
REQ-016 IDLE with start=1 SHALL clear CROM_A, checksum, write count and err, then enter WAITB.
REQ-017 WAITB SHALL move to ISSUE on the first rising edge that samples busy=0.
REQ-018 ISSUE SHALL register cmd<=CROM_Q and assert cmd_valid for exactly one clock.
REQ-019 The cmd value SHALL hold until the next issue.
REQ-020 After issuing a nonzero cmd, the block SHALL increment CROM_A, spend one clock in GAP with cmd_valid=0, then return to WAITB.
REQ-021 Consecutive cmd_valid pulses SHALL therefore be at least 3 clocks apart.
REQ-022 After issuing cmd=0 (write-back), the block SHALL enter CAPT.
REQ-023 Script overflow: if entry 31 is nonzero, the next issue SHALL force cmd=0, set err=1 and SHALL NOT wrap CROM_A.
REQ-024 In CAPT, every rising edge with IRB_RW=0 SHALL write buf[IRB_A]<=IRB_D, add IRB_D to checksum and increment a 7-bit write count.
REQ-025 IRB_RW=0 outside CAPT SHALL be ignored.
REQ-026 CAPT SHALL go to FIN when the write count reaches 64.
REQ-027 If done_lcd=1 in CAPT before 64 writes, the block SHALL go to FIN with err=1.
REQ-028 On a write sampled in the same edge as done_lcd, the write SHALL be captured before the exit.
REQ-029 FIN SHALL hold seq_done=1, cmd_valid=0 and all results.
REQ-030 start=1 in FIN SHALL behave as start in IDLE, with seq_done cleared.
REQ-031 start SHALL be ignored in WAITB, ISSUE, GAP and CAPT.
REQ-032 checksum SHALL be unsigned 16-bit and SHALL NOT saturate; the maximum legal value is 16320.

Reset
REQ-033 reset=0 SHALL force IDLE asynchronously from any state, including mid-ISSUE and mid-CAPT.
REQ-034 Reset values SHALL be: cmd=0, cmd_valid=0, CROM_A=0, checksum=0, seq_done=0, err=0, write count=0.
REQ-035 Buffer contents SHALL NOT be reset, so rd_q is undefined until written.

Configuration
REQ-036 With macro LCD_SEQ_TIMEOUT_EN defined, an 8-bit watchdog SHALL count clocks with busy=1 in WAITB or with no write in CAPT.
REQ-037 With LCD_SEQ_TIMEOUT_EN defined, the watchdog SHALL clear on progress (busy=0 or a write) and on a state change.
REQ-038 With LCD_SEQ_TIMEOUT_EN defined, reaching 255 SHALL set err=1 and enter FIN.
REQ-039 Without LCD_SEQ_TIMEOUT_EN, no watchdog SHALL exist and waiting SHALL be unbounded.

Verification
REQ-040 Script {1,3,5,0}, busy=1 for 70 clocks after start -> no cmd_valid until busy low; then single-clock pulses cmd=1,3,5,0 in order, each at least 3 clocks apart.
REQ-041 64 writes with IRB_A=i, IRB_D=i -> checksum=2016, seq_done=1, err=0; rd_a=10 gives rd_q=10.
REQ-042 32 nonzero script entries -> 33rd pulse carries cmd=0, err=1, CROM_A remains 31.
REQ-043 done_lcd=1 after 40 writes of 0xFF -> FIN, checksum=10200, err=1.
REQ-044 reset=0 pulse mid-CAPT -> all outputs at reset values immediately; a new start completes a normal run.
REQ-045 busy held high 255 clocks in WAITB -> with LCD_SEQ_TIMEOUT_EN: err=1, seq_done=1; without it: still in WAITB after 1000 clocks, cmd_valid=0.
